mem_sequencer: RTL
==================

# mem_sequencer

Multicycle sequencer that shares one single-port unified memory between instruction fetch and load/store data access for the MIPS datapath. It fetches the word at `pc`, holds it on `instr` while the datapath settles, and performs at most one data access. It then pulses `step` to commit the instruction, which enables the PC register and register-file write. It also generates byte enables and lane alignment for byte, halfword and word accesses, and halts on illegal accesses.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width; fixed at 32, 4 byte lanes

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `pc`  in  AW  current PC from the datapath
- `instr`  out  32  fetched instruction, stable from EXEC through COMMIT
- `d_read`  in  1  instruction is a load; sampled in EXEC
- `d_write`  in  1  instruction is a store; sampled in EXEC
- `d_addr`  in  AW  ALU result used as the byte address
- `d_wdata`  in  32  store data (register rt)
- `d_size`  in  2  access size: 00 word, 01 half, 10 byte, 11 illegal
- `d_rdata`  out  32  load data shifted to bit 0, upper bits zero; sign extension is done by the datapath
- `step`  out  1  commit strobe, high exactly while in COMMIT
- `err`  out  1  sticky illegal-access flag
- `mem_req`  out  1  memory request
- `mem_we`  out  1  write enable
- `mem_addr`  out  AW  word-aligned address; bits [1:0] are always 0
- `mem_wdata`  out  32  lane-replicated store data
- `mem_be`  out  4  byte enables; bit i covers bits [8i+7:8i]
- `mem_rdata`  in  32  memory read data
- `mem_ready`  in  1  memory completion, sampled on a rising edge while `mem_req`=1

## Operation
- States: IDLE, FETCH, EXEC, DATA, COMMIT, HALT.
- IDLE:
  - Reset state.
  - Goes to FETCH on the first edge after `reset` deasserts.
- FETCH:
  - Drives `mem_req`=1, `mem_we`=0, `mem_be`=4'hF, `mem_addr`={pc[31:2],2'b00}.
  - On `mem_ready`, captures `mem_rdata` into `instr` and goes to EXEC.
- EXEC:
  - One cycle; `instr` is driving the datapath.
  - At the end of the cycle, samples `d_read`, `d_write`, `d_addr`, `d_wdata`, `d_size`.
  - Next state:
    - neither read nor write: COMMIT
    - exactly one of them, legal access: DATA, with request fields registered
    - both asserted, `d_size`=11, half with addr[0]=1, or word with addr[1:0]≠0: HALT, `err`←1, no memory access issued
- DATA:
  - Drives `mem_req`=1 with the registered fields and `mem_we`=write.
  - Enables and store data by size:
    - byte: `mem_be`=1<<addr[1:0], `mem_wdata`={4{wdata[7:0]}}
    - half: `mem_be`=addr[1]?4'b1100:4'b0011, `mem_wdata`={2{wdata[15:0]}}
    - word: `mem_be`=4'hF, `mem_wdata`=wdata
  - On `mem_ready` with a read, `d_rdata`←(mem_rdata>>(8·addr[1:0])), masked to 8/16/32 bits by size.
  - Then goes to COMMIT.
- COMMIT: `step`=1 for one cycle, then FETCH, which uses the updated `pc`.
- HALT:
  - Terminal state.
  - Drives `step`=0 and `mem_req`=0.
  - Left only by `reset`.
- `d_rdata` holds its value until the next load completes. A store leaves it unchanged.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE
  - `mem_req`, `mem_we`, `step`, `err` = 0
  - `mem_be` = 0, `mem_addr` = 0, `mem_wdata` = 0
  - `instr` = 0, `d_rdata` = 0
- Handshake:
  - While `mem_req`=1, `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` are held stable until the edge at which `mem_ready`=1.
  - `mem_req` drops in the cycle after that edge.
  - `mem_ready` is ignored while `mem_req`=0.
- Zero-wait memory (`mem_ready` tied high):
  - non-memory instruction: 3 cycles (FETCH, EXEC, COMMIT)
  - load or store: 4 cycles
- Each cycle with `mem_ready` low adds one cycle to FETCH or DATA.
- `d_*` inputs are don't-care outside the EXEC sampling edge.
- `pc` must change only on the COMMIT edge.
- Reset asserted mid-access: `mem_req` deasserts immediately, the transaction is abandoned, and no `step` is issued.

## Structure
- Package `mem_seq_pkg` contains:
  - enum `state_t` with the six states
  - `size_t` constants SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10
- Sub-module `lane_align` (combinational):
  - inputs: size, addr[1:0], wdata, rdata
  - outputs: be, replicated wdata, shifted and masked rdata, misalign flag
  - used by both the DATA drive logic and the load capture

## Test plan
- Fetch with `mem_ready` tied high, `pc`=0x40, no data access → `mem_addr`=0x40, `mem_be`=F, `instr`=mem word, `step` high in cycle 3, next fetch of the new pc in cycle 4.
- `mem_ready` held low 2 cycles during fetch → `mem_addr`/`mem_be` stable across 3 request cycles, `step` in cycle 5.
- Store byte, `d_addr`=0x103, `d_wdata`=0x12345678 → `mem_be`=1000, `mem_wdata`=0x78787878, `mem_addr`=0x100, `mem_we`=1.
- Load half, `d_addr`=0x202, `mem_rdata`=0xBEEF1234 → `d_rdata`=0x0000BEEF.
- Load word, `d_addr`=0x301 → HALT, `err`=1, no DATA request, `step` never asserts again; `reset` low then high → `err`=0, fetch resumes.
- Reset asserted mid-DATA with `mem_ready` low → `mem_req`=0 immediately, `step`=0, state IDLE.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared types for the memory sequencer: FSM state encoding and the
// access-size codes carried on d_size.
package mem_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        EXEC   = 3'd2,
        DATA   = 3'd3,
        COMMIT = 3'd4,
        HALT   = 3'd5
    } state_t;

    typedef logic [1:0] size_t;

    localparam size_t SZ_WORD = 2'b00;
    localparam size_t SZ_HALF = 2'b01;
    localparam size_t SZ_BYTE = 2'b10;
    localparam size_t SZ_BAD  = 2'b11;

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering for a 32-bit, 4-lane memory.
// Ports:
//   size        access size (word/half/byte/illegal)
//   addr        byte offset within the word
//   wdata       store data, right-justified
//   rdata       raw memory read word
//   be          byte enables, bit i covers bits [8i+7:8i]
//   wdata_rep   store data replicated across all lanes it may land in
//   rdata_align read data shifted down to bit 0 and zero-masked to size
//   misalign    access cannot be issued (bad size or unaligned)
import mem_seq_pkg::*;

module lane_align (
    input  size_t       size,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_align,
    output logic        misalign
);

    logic [31:0] rdata_shift;

    assign rdata_shift = rdata >> {addr, 3'b000};

    always_comb begin
        be          = 4'h0;
        wdata_rep   = 32'h0;
        rdata_align = 32'h0;
        misalign    = 1'b0;
        case (size)
            SZ_BYTE: begin
                be          = 4'b0001 << addr;
                wdata_rep   = {4{wdata[7:0]}};
                rdata_align = {24'h0, rdata_shift[7:0]};
            end
            SZ_HALF: begin
                be          = addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep   = {2{wdata[15:0]}};
                rdata_align = {16'h0, rdata_shift[15:0]};
                misalign    = addr[0];
            end
            SZ_WORD: begin
                be          = 4'hF;
                wdata_rep   = wdata;
                rdata_align = rdata_shift;
                misalign    = (addr != 2'b00);
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_sequencer.sv
// Multicycle sequencer sharing one single-port memory between instruction
// fetch and a single load/store per instruction, committing with `step`.
// Ports:
//   clk, reset                 clock, async active-low reset
//   pc / instr                 fetch address in, fetched instruction out
//   d_read/d_write/d_addr/d_wdata/d_size   data request, sampled in EXEC
//   d_rdata                    aligned load data, held until next load
//   step                       commit strobe (PC / regfile write enable)
//   err                        sticky illegal-access flag
//   mem_*                      single-port memory request/response
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | out of reset, moves to FETCH on the next edge
// FETCH  | instruction read at pc, waits for mem_ready
// EXEC   | instr drives the datapath; data request sampled at end
// DATA   | one load or store with registered fields, waits for mem_ready
// COMMIT | step high for one cycle
// HALT   | illegal access seen; only reset leaves
import mem_seq_pkg::*;

module mem_sequencer #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc,
    output logic [DW-1:0] instr,
    input  logic          d_read,
    input  logic          d_write,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [1:0]    d_size,
    output logic [DW-1:0] d_rdata,
    output logic          step,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_be,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    state_t        state, state_nxt;

    logic          rq_we;
    logic [AW-1:0] rq_addr;
    logic [DW-1:0] rq_wdata;
    size_t         rq_size;

    size_t         la_size;
    logic [1:0]    la_addr;
    logic [3:0]    la_be;
    logic [DW-1:0] la_wdata;
    logic [DW-1:0] la_rdata;
    logic          la_misalign;

    logic          exec_any;
    logic          exec_illegal;

    // pc is a byte address; fetches are always whole words.
    logic          unused_pc_bits;
    assign unused_pc_bits = ^pc[1:0];

    // The one aligner serves two purposes: in EXEC it judges the incoming
    // request for legality, elsewhere it steers the registered request.
    assign la_size = (state == EXEC) ? size_t'(d_size) : rq_size;
    assign la_addr = (state == EXEC) ? d_addr[1:0]     : rq_addr[1:0];

    lane_align u_lane_align (
        .size        (la_size),
        .addr        (la_addr),
        .wdata       (rq_wdata),
        .rdata       (mem_rdata),
        .be          (la_be),
        .wdata_rep   (la_wdata),
        .rdata_align (la_rdata),
        .misalign    (la_misalign)
    );

    assign exec_any     = d_read | d_write;
    assign exec_illegal = (d_read & d_write) | la_misalign;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            instr    <= '0;
            d_rdata  <= '0;
            err      <= 1'b0;
            rq_we    <= 1'b0;
            rq_addr  <= '0;
            rq_wdata <= '0;
            rq_size  <= SZ_WORD;
        end else begin
            state <= state_nxt;
            if (state == FETCH && mem_ready) begin
                instr <= mem_rdata;
            end
            if (state == EXEC && exec_any) begin
                if (exec_illegal) begin
                    err <= 1'b1;
                end else begin
                    rq_we    <= d_write;
                    rq_addr  <= d_addr;
                    rq_wdata <= d_wdata;
                    rq_size  <= size_t'(d_size);
                end
            end
            if (state == DATA && mem_ready && !rq_we) begin
                d_rdata <= la_rdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        step      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 4'h0;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                mem_req  = 1'b1;
                mem_be   = 4'hF;
                mem_addr = {pc[AW-1:2], 2'b00};
                if (mem_ready) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (!exec_any) begin
                    state_nxt = COMMIT;
                end else if (exec_illegal) begin
                    state_nxt = HALT;
                end else begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                mem_req   = 1'b1;
                mem_we    = rq_we;
                mem_be    = la_be;
                mem_wdata = la_wdata;
                mem_addr  = {rq_addr[AW-1:2], 2'b00};
                if (mem_ready) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                step      = 1'b1;
                state_nxt = FETCH;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

endmodule
